// File: rtl/fwd_operand_stage_if.sv
// ---------------------------------------------------------------------------
// fwd_operand_stage_if
// Bundles every ID-stage, forwarding-source and ID/EX output signal of the
// operand forwarding stage.
//   master : the surrounding pipeline (drives i_*, observes o_*)
//   slave  : fwd_operand_stage (observes i_*, drives o_*)
// Handshake semantics: there is no ready/valid backpressure pair. i_valid
// qualifies the ID instruction, o_stall (combinational) tells IF/ID to keep
// the same instruction for another cycle, and i_hold freezes the ID/EX
// registers. o_valid qualifies the registered ID/EX contents.
// Parameters must match those of the fwd_operand_stage instance it feeds.
// ---------------------------------------------------------------------------
interface fwd_operand_stage_if #(
  parameter int NBITS         = 32,
  parameter int NREG_BITS     = 5,
  parameter int CORTOCIRCUITO = 3,
  parameter int CNT_BITS      = 16
);
  logic                     i_valid;
  logic [NREG_BITS-1:0]     i_rs;
  logic [NREG_BITS-1:0]     i_rt;
  logic                     i_use_rs;
  logic                     i_use_rt;
  logic [NBITS-1:0]         i_rs_data;
  logic [NBITS-1:0]         i_rt_data;
  logic [NREG_BITS-1:0]     i_rd;
  logic                     i_wr_en;
  logic                     i_is_load;
  logic [NBITS-1:0]         i_ex_result;
  logic [NREG_BITS-1:0]     i_exmem_rd;
  logic                     i_exmem_wr;
  logic                     i_exmem_is_load;
  logic [NBITS-1:0]         i_exmem_data;
  logic [NREG_BITS-1:0]     i_memwb_rd;
  logic                     i_memwb_wr;
  logic [NBITS-1:0]         i_memwb_data;
  logic                     i_hold;
  logic                     i_flush;
  logic [NBITS-1:0]         o_opA;
  logic [NBITS-1:0]         o_opB;
  logic [CORTOCIRCUITO-1:0] o_selA;
  logic [CORTOCIRCUITO-1:0] o_selB;
  logic                     o_valid;
  logic [NREG_BITS-1:0]     o_rd;
  logic                     o_wr_en;
  logic                     o_stall;
  logic [CNT_BITS-1:0]      o_stall_cnt;

  modport master (
    output i_valid, i_rs, i_rt, i_use_rs, i_use_rt, i_rs_data, i_rt_data,
           i_rd, i_wr_en, i_is_load, i_ex_result, i_exmem_rd, i_exmem_wr,
           i_exmem_is_load, i_exmem_data, i_memwb_rd, i_memwb_wr,
           i_memwb_data, i_hold, i_flush,
    input  o_opA, o_opB, o_selA, o_selB, o_valid, o_rd, o_wr_en, o_stall,
           o_stall_cnt
  );

  modport slave (
    input  i_valid, i_rs, i_rt, i_use_rs, i_use_rt, i_rs_data, i_rt_data,
           i_rd, i_wr_en, i_is_load, i_ex_result, i_exmem_rd, i_exmem_wr,
           i_exmem_is_load, i_exmem_data, i_memwb_rd, i_memwb_wr,
           i_memwb_data, i_hold, i_flush,
    output o_opA, o_opB, o_selA, o_selB, o_valid, o_rd, o_wr_en, o_stall,
           o_stall_cnt
  );
endinterface

// File: rtl/fwd_operand_stage.sv
// ---------------------------------------------------------------------------
// fwd_operand_stage
// ID-stage operand resolution with prioritised forwarding, load-use hazard
// detection and the ID/EX pipeline register.
// Ports:
//   i_clk   : clock, all state updates on the rising edge
//   i_reset : synchronous active-high reset
//   bus     : fwd_operand_stage_if.slave (ID inputs, forwarding sources,
//             hold/flush controls, registered ID/EX outputs, o_stall and
//             the saturating bubble counter)
// Forwarding select codes: 001 ID/EX, 010 EX/MEM, 011 MEM/WB, 100 history,
// 000 register file. Register 0 always resolves to 000 with data 0.
// ---------------------------------------------------------------------------
module fwd_operand_stage #(
  parameter int NBITS         = 32,
  parameter int NREG_BITS     = 5,
  parameter int CORTOCIRCUITO = 3,
  parameter int CNT_BITS      = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  fwd_operand_stage_if.slave bus
);

  localparam logic [CORTOCIRCUITO-1:0] SEL_RF    = CORTOCIRCUITO'(0);
  localparam logic [CORTOCIRCUITO-1:0] SEL_IDEX  = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] SEL_EXMEM = CORTOCIRCUITO'(2);
  localparam logic [CORTOCIRCUITO-1:0] SEL_MEMWB = CORTOCIRCUITO'(3);
  localparam logic [CORTOCIRCUITO-1:0] SEL_HIST  = CORTOCIRCUITO'(4);

  // ID/EX register contents
  logic [NBITS-1:0]         idex_op_a, idex_op_b;
  logic [CORTOCIRCUITO-1:0] idex_sel_a, idex_sel_b;
  logic                     idex_valid, idex_wr, idex_is_load;
  logic [NREG_BITS-1:0]     idex_rd;
  logic [CNT_BITS-1:0]      stall_cnt;

  // One-entry write-back history for register files that do not write
  // before they read in the same cycle.
  logic                     hist_valid;
  logic [NREG_BITS-1:0]     hist_rd;
  logic [NBITS-1:0]         hist_data;

  function automatic logic src_match(input logic use_op,
                                     input logic [NREG_BITS-1:0] idx,
                                     input logic wr,
                                     input logic [NREG_BITS-1:0] rd);
    return use_op && (idx != '0) && wr && (idx == rd);
  endfunction

  logic a_idex, a_exmem, a_memwb, a_hist;
  logic b_idex, b_exmem, b_memwb, b_hist;

  assign a_idex  = src_match(bus.i_use_rs, bus.i_rs, idex_wr,        idex_rd);
  assign a_exmem = src_match(bus.i_use_rs, bus.i_rs, bus.i_exmem_wr, bus.i_exmem_rd);
  assign a_memwb = src_match(bus.i_use_rs, bus.i_rs, bus.i_memwb_wr, bus.i_memwb_rd);
  assign a_hist  = src_match(bus.i_use_rs, bus.i_rs, hist_valid,     hist_rd);
  assign b_idex  = src_match(bus.i_use_rt, bus.i_rt, idex_wr,        idex_rd);
  assign b_exmem = src_match(bus.i_use_rt, bus.i_rt, bus.i_exmem_wr, bus.i_exmem_rd);
  assign b_memwb = src_match(bus.i_use_rt, bus.i_rt, bus.i_memwb_wr, bus.i_memwb_rd);
  assign b_hist  = src_match(bus.i_use_rt, bus.i_rt, hist_valid,     hist_rd);

  logic [NBITS-1:0]         op_a, op_b;
  logic [CORTOCIRCUITO-1:0] sel_a, sel_b;

  always_comb begin
    sel_a = SEL_RF;
    op_a  = bus.i_rs_data;
    if (bus.i_rs == '0) begin
      op_a = '0;
    end else if (a_idex) begin
      sel_a = SEL_IDEX;  op_a = bus.i_ex_result;
    end else if (a_exmem) begin
      sel_a = SEL_EXMEM; op_a = bus.i_exmem_data;
    end else if (a_memwb) begin
      sel_a = SEL_MEMWB; op_a = bus.i_memwb_data;
    end else if (a_hist) begin
      sel_a = SEL_HIST;  op_a = hist_data;
    end
  end

  always_comb begin
    sel_b = SEL_RF;
    op_b  = bus.i_rt_data;
    if (bus.i_rt == '0) begin
      op_b = '0;
    end else if (b_idex) begin
      sel_b = SEL_IDEX;  op_b = bus.i_ex_result;
    end else if (b_exmem) begin
      sel_b = SEL_EXMEM; op_b = bus.i_exmem_data;
    end else if (b_memwb) begin
      sel_b = SEL_MEMWB; op_b = bus.i_memwb_data;
    end else if (b_hist) begin
      sel_b = SEL_HIST;  op_b = hist_data;
    end
  end

  // A load result is not available until MEM/WB, so a consumer must wait
  // while the load sits in ID/EX or in EX/MEM. Matches are taken
  // independently of forwarding priority.
  logic hazard;
  assign hazard = bus.i_valid &&
                  ((idex_is_load && (a_idex || b_idex)) ||
                   (bus.i_exmem_is_load && (a_exmem || b_exmem)));

  assign bus.o_stall = !i_reset && !bus.i_flush && (bus.i_hold || hazard);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex_op_a    <= '0;
      idex_op_b    <= '0;
      idex_sel_a   <= '0;
      idex_sel_b   <= '0;
      idex_valid   <= 1'b0;
      idex_rd      <= '0;
      idex_wr      <= 1'b0;
      idex_is_load <= 1'b0;
      stall_cnt    <= '0;
      hist_valid   <= 1'b0;
      hist_rd      <= '0;
      hist_data    <= '0;
    end else begin
      // History follows write-back independently of hold/flush.
      if (bus.i_memwb_wr && (bus.i_memwb_rd != '0)) begin
        hist_valid <= 1'b1;
        hist_rd    <= bus.i_memwb_rd;
        hist_data  <= bus.i_memwb_data;
      end
      if (bus.i_flush) begin
        idex_valid   <= 1'b0;
        idex_wr      <= 1'b0;
        idex_is_load <= 1'b0;
      end else if (bus.i_hold) begin
        // freeze: every ID/EX register keeps its value
      end else if (hazard) begin
        idex_valid   <= 1'b0;
        idex_wr      <= 1'b0;
        idex_is_load <= 1'b0;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_BITS'(1);
      end else begin
        idex_op_a    <= op_a;
        idex_op_b    <= op_b;
        idex_sel_a   <= sel_a;
        idex_sel_b   <= sel_b;
        idex_valid   <= bus.i_valid;
        idex_rd      <= bus.i_rd;
        idex_wr      <= bus.i_valid && bus.i_wr_en;
        idex_is_load <= bus.i_valid && bus.i_is_load;
      end
    end
  end

  assign bus.o_opA       = idex_op_a;
  assign bus.o_opB       = idex_op_b;
  assign bus.o_selA      = idex_sel_a;
  assign bus.o_selB      = idex_sel_b;
  assign bus.o_valid     = idex_valid;
  assign bus.o_rd        = idex_rd;
  assign bus.o_wr_en     = idex_wr;
  assign bus.o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fwd_operand_stage.sv
module tb_fwd_operand_stage;

  localparam int CNT_W = 3;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_operand_stage_if #(.NBITS(32), .NREG_BITS(5), .CORTOCIRCUITO(3), .CNT_BITS(CNT_W)) bus ();

  fwd_operand_stage #(.NBITS(32), .NREG_BITS(5), .CORTOCIRCUITO(3), .CNT_BITS(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sa;
    logic [2:0]  sb;
  } idex_t;

  idex_t       m = '0;
  int unsigned m_cnt = 0;
  logic        h_v = 1'b0;
  logic [4:0]  h_rd = '0;
  logic [31:0] h_d = '0;
  logic        last_stall;

  function automatic logic hit(input logic use_op, input logic [4:0] idx,
                               input logic en, input logic [4:0] rd);
    return use_op && idx != 5'd0 && en && idx == rd;
  endfunction

  // Sources listed in priority order; scanning from the lowest priority up
  // leaves the highest-priority hit as the answer.
  function automatic void resolve(input logic use_op, input logic [4:0] idx, input logic [31:0] rf,
                                  output logic [2:0] sel, output logic [31:0] d);
    logic        en[4];
    logic [4:0]  rds[4];
    logic [31:0] ds[4];
    en  = '{m.wr, bus.i_exmem_wr, bus.i_memwb_wr, h_v};
    rds = '{m.rd, bus.i_exmem_rd, bus.i_memwb_rd, h_rd};
    ds  = '{bus.i_ex_result, bus.i_exmem_data, bus.i_memwb_data, h_d};
    sel = 3'd0;
    d   = (idx == 5'd0) ? 32'd0 : rf;
    for (int k = 3; k >= 0; k--)
      if (hit(use_op, idx, en[k], rds[k])) begin
        sel = 3'(k + 1);
        d   = ds[k];
      end
  endfunction

  // One clock: predict, check o_stall before the edge, advance the model,
  // check registered outputs after the edge.
  task automatic tick();
    idex_t       nm;
    int unsigned ncnt;
    logic        nhv, hz, st;
    logic [4:0]  nhrd;
    logic [31:0] nhd, da, db;
    logic [2:0]  sa, sb;
    @(negedge clk);
    resolve(bus.i_use_rs, bus.i_rs, bus.i_rs_data, sa, da);
    resolve(bus.i_use_rt, bus.i_rt, bus.i_rt_data, sb, db);
    hz = bus.i_valid &&
         ((m.ld && (hit(bus.i_use_rs, bus.i_rs, m.wr, m.rd) || hit(bus.i_use_rt, bus.i_rt, m.wr, m.rd))) ||
          (bus.i_exmem_is_load && (hit(bus.i_use_rs, bus.i_rs, bus.i_exmem_wr, bus.i_exmem_rd) ||
                                   hit(bus.i_use_rt, bus.i_rt, bus.i_exmem_wr, bus.i_exmem_rd))));
    st = !rst && !bus.i_flush && (bus.i_hold || hz);
    last_stall = bus.o_stall;
    chk("o_stall", bus.o_stall, st);
    nm = m; ncnt = m_cnt; nhv = h_v; nhrd = h_rd; nhd = h_d;
    if (rst) begin
      nm = '0; ncnt = 0; nhv = 0; nhrd = 0; nhd = 0;
    end else begin
      if (bus.i_memwb_wr && bus.i_memwb_rd != 5'd0) begin
        nhv = 1'b1; nhrd = bus.i_memwb_rd; nhd = bus.i_memwb_data;
      end
      if (bus.i_flush || (!bus.i_hold && hz)) begin
        nm.v = 0; nm.wr = 0; nm.ld = 0;
        if (!bus.i_flush && ncnt < CMAX) ncnt++;
      end else if (!bus.i_hold) begin
        nm = '{v: bus.i_valid, rd: bus.i_rd, wr: bus.i_valid & bus.i_wr_en,
               ld: bus.i_valid & bus.i_is_load, a: da, b: db, sa: sa, sb: sb};
      end
    end
    @(posedge clk);
    m = nm; m_cnt = ncnt; h_v = nhv; h_rd = nhrd; h_d = nhd;
    #1;
    chk("o_valid", bus.o_valid, m.v);
    chk("o_wr_en", bus.o_wr_en, m.wr);
    chk("o_stall_cnt", bus.o_stall_cnt, m_cnt);
    if (m.v) begin
      chk("o_opA", bus.o_opA, m.a);
      chk("o_opB", bus.o_opB, m.b);
      chk("o_selA", bus.o_selA, m.sa);
      chk("o_selB", bus.o_selB, m.sb);
      chk("o_rd", bus.o_rd, m.rd);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle();
    rst = 0;
    bus.i_valid = 0; bus.i_rs = 0; bus.i_rt = 0; bus.i_use_rs = 0; bus.i_use_rt = 0;
    bus.i_rs_data = 0; bus.i_rt_data = 0; bus.i_rd = 0; bus.i_wr_en = 0; bus.i_is_load = 0;
    bus.i_ex_result = 0; bus.i_exmem_rd = 0; bus.i_exmem_wr = 0; bus.i_exmem_is_load = 0;
    bus.i_exmem_data = 0; bus.i_memwb_rd = 0; bus.i_memwb_wr = 0; bus.i_memwb_data = 0;
    bus.i_hold = 0; bus.i_flush = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic id_load_r7();
    idle(); bus.i_valid = 1; bus.i_rd = 7; bus.i_wr_en = 1; bus.i_is_load = 1;
  endtask

  task automatic id_use_r7();
    idle(); bus.i_valid = 1; bus.i_rs = 7; bus.i_use_rs = 1; bus.i_rs_data = 32'hDEAD;
    bus.i_rd = 8; bus.i_wr_en = 1;
  endtask

  logic [CNT_W-1:0] cnt_before;

  initial begin
    idle(); rst = 1;
    tick();
    chk("rst_opA", bus.o_opA, 0);
    chk("rst_selA", bus.o_selA, 0);
    chk("rst_rd", bus.o_rd, 0);
    chk("rst_cnt", bus.o_stall_cnt, 0);
    rst = 0;

    // no dependence
    idle(); bus.i_valid = 1; bus.i_rs = 3; bus.i_use_rs = 1; bus.i_rs_data = 32'h11; tick();
    chk("nodep_opA", bus.o_opA, 32'h11);
    chk("nodep_selA", bus.o_selA, 0);
    chk("nodep_valid", bus.o_valid, 1);

    // ALU back-to-back, ID/EX beats EX/MEM
    idle(); bus.i_valid = 1; bus.i_rd = 5; bus.i_wr_en = 1; tick();
    idle(); bus.i_valid = 1; bus.i_rs = 5; bus.i_use_rs = 1; bus.i_ex_result = 32'h2A;
    bus.i_exmem_rd = 5; bus.i_exmem_wr = 1; bus.i_exmem_data = 32'h99; tick();
    chk("alu_opA", bus.o_opA, 32'h2A);
    chk("alu_selA", bus.o_selA, 1);

    // load-use: two bubbles then MEM/WB forward
    do_reset();
    id_load_r7(); tick();
    id_use_r7(); tick();
    chk("lu_stall1", last_stall, 1);
    chk("lu_bubble1", bus.o_valid, 0);
    id_use_r7(); bus.i_exmem_rd = 7; bus.i_exmem_wr = 1; bus.i_exmem_is_load = 1; tick();
    chk("lu_stall2", last_stall, 1);
    chk("lu_bubble2", bus.o_valid, 0);
    id_use_r7(); bus.i_memwb_rd = 7; bus.i_memwb_wr = 1; bus.i_memwb_data = 32'h1234; tick();
    chk("lu_stall3", last_stall, 0);
    chk("lu_opA", bus.o_opA, 32'h1234);
    chk("lu_selA", bus.o_selA, 3);
    chk("lu_cnt", bus.o_stall_cnt, 2);

    // history covers stale register file
    idle(); bus.i_memwb_rd = 9; bus.i_memwb_wr = 1; bus.i_memwb_data = 32'hBEEF; tick();
    idle(); bus.i_valid = 1; bus.i_rt = 9; bus.i_use_rt = 1; bus.i_rt_data = 0; tick();
    chk("hist_opB", bus.o_opB, 32'hBEEF);
    chk("hist_selB", bus.o_selB, 4);

    // register 0
    idle(); bus.i_valid = 1; bus.i_rs = 0; bus.i_use_rs = 1; bus.i_rs_data = 32'h77;
    bus.i_exmem_rd = 0; bus.i_exmem_wr = 1; bus.i_exmem_data = 32'h55; tick();
    chk("r0_opA", bus.o_opA, 0);
    chk("r0_selA", bus.o_selA, 0);

    // flush during hazard
    id_load_r7(); tick();
    cnt_before = bus.o_stall_cnt;
    id_use_r7(); bus.i_flush = 1; tick();
    chk("flush_stall", last_stall, 0);
    chk("flush_valid", bus.o_valid, 0);
    chk("flush_cnt", bus.o_stall_cnt, cnt_before);

    // hold during hazard
    id_load_r7(); tick();
    cnt_before = bus.o_stall_cnt;
    id_use_r7(); bus.i_hold = 1; tick();
    chk("hold_stall", last_stall, 1);
    chk("hold_valid", bus.o_valid, 1);
    chk("hold_rd", bus.o_rd, 7);
    chk("hold_cnt", bus.o_stall_cnt, cnt_before);
    id_use_r7(); tick();

    // reset mid-stall
    id_load_r7(); tick();
    id_use_r7(); tick();
    id_use_r7(); bus.i_exmem_rd = 7; bus.i_exmem_wr = 1; bus.i_exmem_is_load = 1; rst = 1; tick();
    chk("rstm_stall", last_stall, 0);
    chk("rstm_valid", bus.o_valid, 0);
    chk("rstm_opA", bus.o_opA, 0);
    chk("rstm_cnt", bus.o_stall_cnt, 0);
    rst = 0;

    // counter saturation: EX/MEM load keeps the consumer stalled
    for (int i = 0; i < int'(CMAX) + 2; i++) begin
      id_use_r7(); bus.i_exmem_rd = 7; bus.i_exmem_wr = 1; bus.i_exmem_is_load = 1; tick();
    end
    chk("sat_cnt", bus.o_stall_cnt, CMAX);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      bus.i_valid = $urandom_range(1); bus.i_rs = $urandom_range(7); bus.i_rt = $urandom_range(7);
      bus.i_use_rs = $urandom_range(1); bus.i_use_rt = $urandom_range(1);
      bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
      bus.i_rd = $urandom_range(7); bus.i_wr_en = $urandom_range(1); bus.i_is_load = $urandom_range(1);
      bus.i_ex_result = $urandom;
      bus.i_exmem_rd = $urandom_range(7); bus.i_exmem_wr = $urandom_range(1);
      bus.i_exmem_is_load = ($urandom_range(3) == 0); bus.i_exmem_data = $urandom;
      bus.i_memwb_rd = $urandom_range(7); bus.i_memwb_wr = $urandom_range(1); bus.i_memwb_data = $urandom;
      bus.i_hold = ($urandom_range(15) == 0); bus.i_flush = ($urandom_range(15) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
